// File: rtl/noc_endp_pkg.sv
// Shared sizing helpers for NoC endpoint logic: log2, derived widths and
// header-payload field offsets (payload packed LSB-up: src, dest, destport, class, weight, be, data).
package noc_endp_pkg;

    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int unsigned ea_w(input int unsigned t1, input int unsigned t2,
                                         input int unsigned t3);
        return log2(t1) + log2(t2) + log2(t3);
    endfunction

    function automatic int unsigned ne_w(input int unsigned t1, input int unsigned t2,
                                         input int unsigned t3);
        return log2(t1 * t2 * t3);
    endfunction

    function automatic int unsigned dist_w(input int unsigned t1, input int unsigned t2);
        return log2(t1 + t2);
    endfunction

    function automatic int unsigned flit_w(input int unsigned fpay, input int unsigned v);
        return fpay + v + 2;
    endfunction

    // Signed so an overfull payload shows up as a value below 1.
    function automatic int data_w(input int fpay, input int eaw, input int dstpw,
                                  input int cw, input int weightw, input int bew);
        return fpay - (2 * eaw + dstpw + cw + weightw + bew);
    endfunction

    localparam int unsigned OFF_SRC = 0;

    function automatic int unsigned off_dest(input int unsigned eaw);
        return eaw;
    endfunction

    function automatic int unsigned off_destport(input int unsigned eaw);
        return 2 * eaw;
    endfunction

    function automatic int unsigned off_class(input int unsigned eaw, input int unsigned dstpw);
        return 2 * eaw + dstpw;
    endfunction

    function automatic int unsigned off_weight(input int unsigned eaw, input int unsigned dstpw,
                                               input int unsigned cw);
        return 2 * eaw + dstpw + cw;
    endfunction

    function automatic int unsigned off_be(input int unsigned eaw, input int unsigned dstpw,
                                           input int unsigned cw, input int unsigned weightw);
        return 2 * eaw + dstpw + cw + weightw;
    endfunction

    function automatic int unsigned off_data(input int unsigned eaw, input int unsigned dstpw,
                                             input int unsigned cw, input int unsigned weightw,
                                             input int unsigned bew);
        return 2 * eaw + dstpw + cw + weightw + bew;
    endfunction

endpackage

// File: rtl/mesh_addr_decode.sv
// Splits a mesh endpoint address into x/y and a linear endpoint ID;
// any out-of-range field flags err and forces the ID to zero.
module mesh_addr_decode
    import noc_endp_pkg::*;
#(
    parameter int unsigned T1 = 4,
    parameter int unsigned T2 = 4,
    parameter int unsigned T3 = 1,
    localparam int unsigned Xw  = log2(T1),
    localparam int unsigned Yw  = log2(T2),
    localparam int unsigned Lw  = log2(T3),
    localparam int unsigned EAw = Xw + Yw + Lw,
    localparam int unsigned NEw = ne_w(T1, T2, T3)
) (
    input  logic [EAw-1:0] i_addr,
    output logic [NEw-1:0] o_id,
    output logic [Xw-1:0]  o_x,
    output logic [Yw-1:0]  o_y,
    output logic           o_err
);

    logic [Lw-1:0] w_l;
    logic [31:0]   w_lin;

    assign o_x = i_addr[Xw-1:0];
    assign o_y = i_addr[Xw+Yw-1:Xw];
    assign w_l = i_addr[EAw-1:Xw+Yw];

    always_comb begin
        o_err = (32'(o_x) >= T1) || (32'(o_y) >= T2) || (32'(w_l) >= T3);
        w_lin = ((32'(o_y) * T1) + 32'(o_x)) * T3 + 32'(w_l);
        o_id  = o_err ? '0 : NEw'(w_lin);
    end

endmodule

// File: rtl/endp_header_distance_unit.sv
// Endpoint helper: packs a header flit, decodes src/dest endpoint IDs and
// registers the Manhattan hop distance, all one cycle after the request.
module endp_header_distance_unit
    import noc_endp_pkg::*;
#(
    parameter int unsigned T1      = 4,
    parameter int unsigned T2      = 4,
    parameter int unsigned T3      = 1,
    parameter int unsigned V       = 2,
    parameter int unsigned C       = 2,
    parameter int unsigned Fpay    = 32,
    parameter int unsigned DSTPw   = 4,
    parameter int unsigned WEIGHTw = 4,
    parameter int unsigned BEw     = 1,
    localparam int unsigned Xw     = log2(T1),
    localparam int unsigned Yw     = log2(T2),
    localparam int unsigned EAw    = ea_w(T1, T2, T3),
    localparam int unsigned Cw     = log2(C),
    localparam int unsigned NEw    = ne_w(T1, T2, T3),
    localparam int unsigned DISTw  = dist_w(T1, T2),
    localparam int unsigned Fw     = flit_w(Fpay, V),
    localparam int          DATA_w = data_w(Fpay, EAw, DSTPw, Cw, WEIGHTw, BEw)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [EAw-1:0]     src_e_addr,
    input  logic [EAw-1:0]     dest_e_addr,
    input  logic [V-1:0]       vc_in,
    input  logic [Cw-1:0]      class_in,
    input  logic [DSTPw-1:0]   destport_in,
    input  logic [WEIGHTw-1:0] weight_in,
    input  logic [BEw-1:0]     be_in,
    input  logic [DATA_w-1:0]  data_in,
    input  logic               tail_in,
    output logic               out_valid,
    output logic [Fw-1:0]      flit_out,
    output logic [NEw-1:0]     src_id,
    output logic [NEw-1:0]     dst_id,
    output logic [DISTw-1:0]   distance,
    output logic               addr_err
);

    localparam int unsigned OFF_DEST  = off_dest(EAw);
    localparam int unsigned OFF_DSTP  = off_destport(EAw);
    localparam int unsigned OFF_CLASS = off_class(EAw, DSTPw);
    localparam int unsigned OFF_WGT   = off_weight(EAw, DSTPw, Cw);
    localparam int unsigned OFF_BE    = off_be(EAw, DSTPw, Cw, WEIGHTw);
    localparam int unsigned OFF_DATA  = off_data(EAw, DSTPw, Cw, WEIGHTw, BEw);

    if (DATA_w < 1) begin : g_data_w_check
        $error("endp_header_distance_unit: header fields leave no room for data (DATA_w < 1)");
    end

    logic [NEw-1:0]   w_src_id, w_dst_id;
    logic [Xw-1:0]    w_src_x, w_dst_x, w_dx;
    logic [Yw-1:0]    w_src_y, w_dst_y, w_dy;
    logic             w_src_err, w_dst_err, w_err;
    logic [DISTw-1:0] w_dist;
    logic [Fpay-1:0]  w_payload;
    logic [Fw-1:0]    w_flit;

    logic             r_valid;
    logic [Fw-1:0]    r_flit;
    logic [NEw-1:0]   r_src_id, r_dst_id;
    logic [DISTw-1:0] r_dist;
    logic             r_err;

    mesh_addr_decode #(.T1(T1), .T2(T2), .T3(T3)) u_src_decode (
        .i_addr (src_e_addr),
        .o_id   (w_src_id),
        .o_x    (w_src_x),
        .o_y    (w_src_y),
        .o_err  (w_src_err)
    );

    mesh_addr_decode #(.T1(T1), .T2(T2), .T3(T3)) u_dst_decode (
        .i_addr (dest_e_addr),
        .o_id   (w_dst_id),
        .o_x    (w_dst_x),
        .o_y    (w_dst_y),
        .o_err  (w_dst_err)
    );

    // The local field is not part of the hop count, so same-router pairs give zero.
    always_comb begin
        w_err  = w_src_err | w_dst_err;
        w_dx   = (w_src_x >= w_dst_x) ? (w_src_x - w_dst_x) : (w_dst_x - w_src_x);
        w_dy   = (w_src_y >= w_dst_y) ? (w_src_y - w_dst_y) : (w_dst_y - w_src_y);
        w_dist = w_err ? '0 : (DISTw'(w_dx) + DISTw'(w_dy));
    end

    always_comb begin
        w_payload = '0;
        w_payload[OFF_SRC   +: EAw]     = src_e_addr;
        w_payload[OFF_DEST  +: EAw]     = dest_e_addr;
        w_payload[OFF_DSTP  +: DSTPw]   = destport_in;
        w_payload[OFF_CLASS +: Cw]      = class_in;
        w_payload[OFF_WGT   +: WEIGHTw] = weight_in;
        w_payload[OFF_BE    +: BEw]     = be_in;
        w_payload[OFF_DATA  +: DATA_w]  = data_in;
        w_flit = {1'b1, tail_in, vc_in, w_payload};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_flit   <= '0;
            r_src_id <= '0;
            r_dst_id <= '0;
            r_dist   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_flit   <= w_flit;
                r_src_id <= w_src_id;
                r_dst_id <= w_dst_id;
                r_dist   <= w_dist;
                r_err    <= w_err;
            end
        end
    end

    assign out_valid = r_valid;
    assign flit_out  = r_flit;
    assign src_id    = r_src_id;
    assign dst_id    = r_dst_id;
    assign distance  = r_dist;
    assign addr_err  = r_err;

endmodule

// File: tb/tb_endp_header_distance_unit.sv
// Directed bench for endp_header_distance_unit: default 4x4 mesh plus a
// second instance with two endpoints per router.
module tb_endp_header_distance_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  src_e_addr = '0;
    logic [4:0]  dest_e_addr = '0;
    logic [1:0]  vc_in = '0;
    logic        class_in = 1'b0;
    logic [3:0]  destport_in = '0;
    logic [3:0]  weight_in = '0;
    logic        be_in = 1'b0;
    logic [11:0] data_in = '0;
    logic        tail_in = 1'b0;

    logic        out_valid;
    logic [35:0] flit_out;
    logic [3:0]  src_id, dst_id;
    logic [2:0]  distance;
    logic        addr_err;

    logic        b_out_valid;
    logic [35:0] b_flit_out;
    logic [4:0]  b_src_id, b_dst_id;
    logic [2:0]  b_distance;
    logic        b_addr_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    endp_header_distance_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .src_e_addr(src_e_addr), .dest_e_addr(dest_e_addr), .vc_in(vc_in),
        .class_in(class_in), .destport_in(destport_in), .weight_in(weight_in),
        .be_in(be_in), .data_in(data_in), .tail_in(tail_in),
        .out_valid(out_valid), .flit_out(flit_out), .src_id(src_id),
        .dst_id(dst_id), .distance(distance), .addr_err(addr_err)
    );

    endp_header_distance_unit #(.T3(2)) dut_t3 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .src_e_addr(src_e_addr), .dest_e_addr(dest_e_addr), .vc_in(vc_in),
        .class_in(class_in), .destport_in(destport_in), .weight_in(weight_in),
        .be_in(be_in), .data_in(data_in), .tail_in(tail_in),
        .out_valid(b_out_valid), .flit_out(b_flit_out), .src_id(b_src_id),
        .dst_id(b_dst_id), .distance(b_distance), .addr_err(b_addr_err)
    );

    task automatic apply(input logic v, input logic [4:0] s, input logic [4:0] d);
        in_valid    = v;
        src_e_addr  = s;
        dest_e_addr = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", out_valid); else n_pass++;
        n_total++; if (flit_out !== 36'h0) $display("FAIL reset_flit got %0h exp 0", flit_out); else n_pass++;
        n_total++; if ({src_id, dst_id, distance, addr_err} !== 12'h0)
            $display("FAIL reset_fields got %0h exp 0", {src_id, dst_id, distance, addr_err}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_decode_distance();
        // src (x1,y2) -> 9, dest (x3,y0) -> 3
        apply(1'b1, 5'd9, 5'd3);
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL dd_valid got %0h exp 1", out_valid); else n_pass++;
        n_total++; if (src_id !== 4'd9) $display("FAIL dd_src_id got %0d exp 9", src_id); else n_pass++;
        n_total++; if (dst_id !== 4'd3) $display("FAIL dd_dst_id got %0d exp 3", dst_id); else n_pass++;
        n_total++; if (distance !== 3'd4) $display("FAIL dd_distance got %0d exp 4", distance); else n_pass++;
        n_total++; if (addr_err !== 1'b0) $display("FAIL dd_addr_err got %0h exp 0", addr_err); else n_pass++;
    endtask

    task automatic test_same_router();
        apply(1'b1, 5'd10, 5'd10);
        step();
        n_total++; if (distance !== 3'd0) $display("FAIL same_distance got %0d exp 0", distance); else n_pass++;
        n_total++; if (src_id !== 4'd10) $display("FAIL same_src_id got %0d exp 10", src_id); else n_pass++;
        n_total++; if (dst_id !== 4'd10) $display("FAIL same_dst_id got %0d exp 10", dst_id); else n_pass++;
    endtask

    task automatic test_header_packing();
        class_in = 1'b1; weight_in = 4'd5; destport_in = 4'd3; vc_in = 2'b10;
        data_in = 12'hABC; be_in = 1'b1; tail_in = 1'b0;
        apply(1'b1, 5'd9, 5'd3);
        step();
        n_total++; if (flit_out !== 36'hA_ABCA_CC69) $display("FAIL hdr_flit got %0h exp aabcacc69", flit_out); else n_pass++;
        n_total++; if (flit_out[35:32] !== 4'b1010) $display("FAIL hdr_ctrl got %0b exp 1010", flit_out[35:32]); else n_pass++;
        n_total++; if (flit_out[31:20] !== 12'hABC) $display("FAIL hdr_data got %0h exp abc", flit_out[31:20]); else n_pass++;
        n_total++; if (flit_out[18:14] !== 5'b01011) $display("FAIL hdr_wgt_class got %0b exp 01011", flit_out[18:14]); else n_pass++;
        n_total++; if (flit_out[13:0] !== {4'd3, 5'd3, 5'd9}) $display("FAIL hdr_low got %0h exp c69", flit_out[13:0]); else n_pass++;
        tail_in = 1'b1; vc_in = 2'b01;
        step();
        n_total++; if (flit_out[35:32] !== 4'b1101) $display("FAIL hdr_tail_vc got %0b exp 1101", flit_out[35:32]); else n_pass++;
        tail_in = 1'b0;
    endtask

    task automatic test_t3_local();
        // src (x1,y2,l1) -> 19, dest (x0,y0,l1) -> 1 with two endpoints per router
        apply(1'b1, 5'd25, 5'd16);
        step();
        n_total++; if (b_dst_id !== 5'd1) $display("FAIL t3_dst_id got %0d exp 1", b_dst_id); else n_pass++;
        n_total++; if (b_src_id !== 5'd19) $display("FAIL t3_src_id got %0d exp 19", b_src_id); else n_pass++;
        n_total++; if (b_distance !== 3'd3) $display("FAIL t3_distance got %0d exp 3", b_distance); else n_pass++;
        n_total++; if (b_addr_err !== 1'b0) $display("FAIL t3_addr_err got %0h exp 0", b_addr_err); else n_pass++;
    endtask

    task automatic test_illegal_addr();
        apply(1'b1, 5'd9, 5'd16);
        step();
        n_total++; if (addr_err !== 1'b1) $display("FAIL ill_addr_err got %0h exp 1", addr_err); else n_pass++;
        n_total++; if (dst_id !== 4'd0) $display("FAIL ill_dst_id got %0d exp 0", dst_id); else n_pass++;
        n_total++; if (distance !== 3'd0) $display("FAIL ill_distance got %0d exp 0", distance); else n_pass++;
        n_total++; if (src_id !== 4'd9) $display("FAIL ill_src_id got %0d exp 9", src_id); else n_pass++;
        apply(1'b1, 5'd20, 5'd3);
        step();
        n_total++; if ({addr_err, src_id, dst_id} !== {1'b1, 4'd0, 4'd3})
            $display("FAIL ill_src got %0h exp 103", {addr_err, src_id, dst_id}); else n_pass++;
    endtask

    task automatic test_hold();
        apply(1'b1, 5'd9, 5'd3);
        step();
        apply(1'b0, 5'd10, 5'd10);
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL hold_valid got %0h exp 0", out_valid); else n_pass++;
        n_total++; if ({src_id, dst_id, distance} !== {4'd9, 4'd3, 3'd4})
            $display("FAIL hold_fields got %0h exp %0h", {src_id, dst_id, distance}, {4'd9, 4'd3, 3'd4}); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        apply(1'b1, 5'd10, 5'd3);
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got %0h exp 1", out_valid); else n_pass++;
        apply(1'b1, 5'd15, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        n_total++; if ({out_valid, flit_out} !== 37'h0) $display("FAIL mid_async_clear got %0h exp 0", {out_valid, flit_out}); else n_pass++;
        n_total++; if ({src_id, dst_id, distance, addr_err} !== 12'h0)
            $display("FAIL mid_async_fields got %0h exp 0", {src_id, dst_id, distance, addr_err}); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_held_valid got %0h exp 0", out_valid); else n_pass++;
        apply(1'b0, 5'd0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        n_total++; if ({out_valid, src_id} !== 5'h0) $display("FAIL mid_idle got %0h exp 0", {out_valid, src_id}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 5'd0, 5'd15);
        step();
        n_total++; if ({out_valid, src_id, dst_id, distance} !== {1'b1, 4'd0, 4'd15, 3'd6})
            $display("FAIL b2b_0 got %0h exp %0h", {out_valid, src_id, dst_id, distance}, {1'b1, 4'd0, 4'd15, 3'd6}); else n_pass++;
        apply(1'b1, 5'd15, 5'd0);
        step();
        n_total++; if ({out_valid, src_id, dst_id, distance} !== {1'b1, 4'd15, 4'd0, 3'd6})
            $display("FAIL b2b_1 got %0h exp %0h", {out_valid, src_id, dst_id, distance}, {1'b1, 4'd15, 4'd0, 3'd6}); else n_pass++;
        apply(1'b1, 5'd5, 5'd10);
        step();
        n_total++; if ({out_valid, src_id, dst_id, distance} !== {1'b1, 4'd5, 4'd10, 3'd2})
            $display("FAIL b2b_2 got %0h exp %0h", {out_valid, src_id, dst_id, distance}, {1'b1, 4'd5, 4'd10, 3'd2}); else n_pass++;
        apply(1'b0, 5'd0, 5'd0);
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_end_valid got %0h exp 0", out_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_decode_distance();
        test_same_router();
        test_header_packing();
        test_t3_local();
        test_illegal_addr();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/endp_header_distance_unit.md
# endp_header_distance_unit

Registered endpoint-side helper for a 2D-mesh NoC. It packs a packet's routing and control fields into a header flit, decodes source and destination endpoint addresses into linear endpoint IDs, and computes their Manhattan hop distance. It sits between a traffic injector or ejector and the router local port. All results appear one cycle after the request is sampled.

## Interface
Parameters:
- T1, 4: routers in X.
- T2, 4: routers in Y.
- T3, 1: endpoints per router.
- V, 2: virtual channels, one-hot.
- C, 2: message classes.
- Fpay, 32: flit payload width.
- DSTPw, 4: destination-port field width.
- WEIGHTw, 4: weight field width.
- BEw, 1: byte-enable field width.
- Derived, with log2(n) = max(1, ceil(log2 n)):
  - Xw = log2(T1), Yw = log2(T2), Lw = log2(T3), EAw = Xw+Yw+Lw.
  - Cw = log2(C), NE = T1·T2·T3, NEw = log2(NE), DISTw = log2(T1+T2).
  - Fw = Fpay+V+2, DATA_w = Fpay−(2·EAw+DSTPw+Cw+WEIGHTw+BEw); elaboration error if DATA_w < 1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low.
- in_valid, input, 1: request strobe.
- src_e_addr, input, EAw: source endpoint address.
- dest_e_addr, input, EAw: destination endpoint address.
- vc_in, input, V: one-hot VC.
- class_in, input, Cw: message class.
- destport_in, input, DSTPw: precomputed destination port.
- weight_in, input, WEIGHTw: weight.
- be_in, input, BEw: byte enable.
- data_in, input, DATA_w: header data.
- tail_in, input, 1: single-flit packet.
- out_valid, output, 1: result valid.
- flit_out, output, Fw: header flit.
- src_id, output, NEw: linear ID of the source endpoint.
- dst_id, output, NEw: linear ID of the destination endpoint.
- distance, output, DISTw: hop count.
- addr_err, output, 1: illegal address seen.

## Operation
- Address encoding, LSB first: x[Xw-1:0], y[Xw+Yw-1:Xw], l[EAw-1:Xw+Yw].
- Endpoint decode: id = ((y·T1)+x)·T3 + l.
  - A field out of range (x≥T1, y≥T2 or l≥T3) forces id = 0 and asserts addr_err.
  - addr_err is the OR over the src and dest decodes.
- Distance = |xs−xd| + |ys−yd|, unsigned. The local field is ignored, so same-router endpoints give 0.
  - If addr_err is set, distance = 0.
- Flit layout, MSB to LSB: hdr_flag(=1), tail_flag(=tail_in), vc[V], then the payload.
- Payload, LSB up: src[EAw], dest[EAw], destport[DSTPw], class[Cw], weight[WEIGHTw], be[BEw], data[DATA_w].
- When in_valid=0, registers hold their last values and out_valid=0 on the next cycle.
- vc_in is passed through unchecked. The sender guarantees it is one-hot.

## Timing
- Latency 1: inputs are sampled on the clk rising edge with in_valid=1, and outputs are valid in the following cycle with out_valid=1.
- Throughput of one request per cycle. No backpressure.
- Reset (reset=0), asynchronous and immediate:
  - all outputs → 0, including flit_out (hdr_flag=0), ids, distance, addr_err, out_valid.
- Reset asserted mid-operation discards the in-flight result. The first valid output is the cycle after the first post-reset in_valid.
- The address decode and distance logic are combinational ahead of the output register. There is no multi-cycle path.

## Structure
- Shared package `noc_endp_pkg`: the log2 function, derived widths (EAw, NEw, DISTw, Fw, DATA_w) and field-offset localparams for the header payload.
- One natural sub-module, `mesh_addr_decode`, instantiated twice (src and dest):
  - input: address.
  - outputs: id, x, y, err.
- Flit packing and distance logic sit in the top level.

## Test plan
- Defaults, src=addr(x1,y2,l0), dest=addr(x3,y0,l0), in_valid=1 → next cycle: out_valid=1, src_id=9, dst_id=3, distance=4, addr_err=0.
- Same router (src=dest=addr(2,2)) → distance=0, src_id=dst_id=10.
- Header packing, defaults: class=1, weight=5, destport=3, vc=2'b10, data=12'hABC, tail_in=0 → verify:
  - flit_out[35]=1, flit_out[34]=0, flit_out[33:32]=2'b10.
  - payload fields at the stated offsets.
- T3=2, Lw=1, dest=addr(x0,y0,l1) → dst_id=1.
- Illegal address: dest with l=1 while T3=1 → addr_err=1, dst_id=0, distance=0.
- reset pulsed low between two valid requests → outputs 0 asynchronously; back-to-back valids afterwards produce one result per cycle.
